xmux_sched: RTL

Programmable select sequencer for the Versat 4-input registered multiplexer. It stores a short table of (select, hold-duration) entries and, on a `run` pulse, steps the mux `sel` through that table for a programmed number of iterations. It then raises `done` once the last selected operand has been registered by the mux. It sits beside each mux functional unit and is written through the Versat configuration bus.

---
 rtl/xmux_sched_pkg.sv | 22 ++
 rtl/xmux_sched_table.sv | 41 ++++
 rtl/xmux_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/xmux_sched_pkg.sv
// xmux_sched_pkg: shared definitions for the Versat mux select sequencer.
//   - state_t    : FSM state encodings (IDLE=0, ACTIVE=1, FLUSH=2, DELAY=3)
//   - MUX_SEL_W  : width of the mux select
//   - Table entry layout is {sel, dur}: sel occupies the top MUX_SEL_W bits,
//     dur the low DUR_W bits (DUR_W is a per-instance parameter).
// No ports; imported by xmux_sched and xmux_sched_table.
package xmux_sched_pkg;

    localparam int MUX_SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DELAY  = 2'd3
    } state_t;

    function automatic int entry_w(input int dur_w);
        return MUX_SEL_W + dur_w;
    endfunction

endpackage

// File: rtl/xmux_sched_table.sv
// xmux_sched_table: N_ENTRIES x {sel, dur} register file for the sequencer.
// Ports:
//   clk, rst        clock, async active-high reset (clears every entry)
//   we              write strobe (already gated to IDLE by the parent)
//   waddr/wsel/wdur write port
//   raddr           combinational read address (entry pointer)
//   rsel/rdur       read data
module xmux_sched_table
    import xmux_sched_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int DUR_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr,
    input  logic [MUX_SEL_W-1:0]         wsel,
    input  logic [DUR_W-1:0]             wdur,
    input  logic [$clog2(N_ENTRIES)-1:0] raddr,
    output logic [MUX_SEL_W-1:0]         rsel,
    output logic [DUR_W-1:0]             rdur
);

    localparam int EW = entry_w(DUR_W);

    logic [EW-1:0] mem [N_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= {wsel, wdur};
        end
    end

    assign {rsel, rdur} = mem[raddr];

endmodule

// File: rtl/xmux_sched.sv
// xmux_sched: programmable select sequencer for the Versat 4-input mux.
// Steps sel through a {sel, dur} table for cfg_iter+1 passes over entries
// 0..cfg_len, then spends one FLUSH cycle so the mux registers the last
// operand, then returns to IDLE (done=1).
// Optional feature macro: XMUX_SCHED_DELAY_EN adds cfg_delay and a DELAY
// state inserted between run and the first ACTIVE cycle.
// Ports:
//   clk, rst            clock, async active-high reset
//   run                 start pulse, honoured only in IDLE
//   done                high while IDLE
//   cfg_we/addr/sel/dur table write port, honoured only in IDLE
//   cfg_len, cfg_iter   last entry index / last pass index, latched on run
//   cfg_delay           (macro only) pre-sequence delay, latched on run
//   sel, en, last       mux select, select-valid, final scheduled cycle
//
// state  | meaning
// IDLE   | block free, table writable, waiting for run
// DELAY  | counting cfg_delay cycles before the sequence (macro only)
// ACTIVE | driving table[ptr].sel for dur+1 cycles per entry
// FLUSH  | one idle cycle so the mux registers the final operand
module xmux_sched
    import xmux_sched_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int DUR_W     = 8,
    parameter int ITER_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    output logic                         done,
    input  logic                         cfg_we,
    input  logic [$clog2(N_ENTRIES)-1:0] cfg_addr,
    input  logic [MUX_SEL_W-1:0]         cfg_sel,
    input  logic [DUR_W-1:0]             cfg_dur,
    input  logic [$clog2(N_ENTRIES)-1:0] cfg_len,
    input  logic [ITER_W-1:0]            cfg_iter,
`ifdef XMUX_SCHED_DELAY_EN
    input  logic [DUR_W-1:0]             cfg_delay,
`endif
    output logic [MUX_SEL_W-1:0]         sel,
    output logic                         en,
    output logic                         last
);

    localparam int AW = $clog2(N_ENTRIES);

    state_t               state, state_nx;
    logic [AW-1:0]        ptr, len_q;
    logic [ITER_W-1:0]    pass, iter_q;
    logic [DUR_W-1:0]     hold;
    logic [MUX_SEL_W-1:0] sel_q, tbl_sel;
    logic [DUR_W-1:0]     tbl_dur;
    logic                 hold_tc, seq_end;

    xmux_sched_table #(
        .N_ENTRIES (N_ENTRIES),
        .DUR_W     (DUR_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && (state == ST_IDLE)),
        .waddr (cfg_addr),
        .wsel  (cfg_sel),
        .wdur  (cfg_dur),
        .raddr (ptr),
        .rsel  (tbl_sel),
        .rdur  (tbl_dur)
    );

    assign hold_tc = (hold == tbl_dur);
    assign seq_end = hold_tc && (ptr == len_q) && (pass == iter_q);

`ifdef XMUX_SCHED_DELAY_EN
    logic [DUR_W-1:0] dly_cnt, dly_lim;
    logic             dly_tc;

    assign dly_tc = (dly_cnt == dly_lim);

    // dly_lim holds cfg_delay-1 so DELAY lasts exactly cfg_delay cycles;
    // a zero delay never enters DELAY, so the underflow value is unused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt <= '0;
            dly_lim <= '0;
        end else if (state == ST_IDLE) begin
            if (run) begin
                dly_cnt <= '0;
                dly_lim <= cfg_delay - 1'b1;
            end
        end else if (state == ST_DELAY && !dly_tc) begin
            dly_cnt <= dly_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (run) begin
`ifdef XMUX_SCHED_DELAY_EN
                    state_nx = (cfg_delay != '0) ? ST_DELAY : ST_ACTIVE;
`else
                    state_nx = ST_ACTIVE;
`endif
                end
            end
            ST_DELAY: begin
`ifdef XMUX_SCHED_DELAY_EN
                if (dly_tc) begin
                    state_nx = ST_ACTIVE;
                end
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_ACTIVE: begin
                if (seq_end) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            pass   <= '0;
            hold   <= '0;
            len_q  <= '0;
            iter_q <= '0;
            sel_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        len_q  <= cfg_len;
                        iter_q <= cfg_iter;
                        ptr    <= '0;
                        pass   <= '0;
                        hold   <= '0;
                    end
                end
                ST_ACTIVE: begin
                    // sel_q remembers the live select so FLUSH/IDLE keep it
                    sel_q <= tbl_sel;
                    if (!hold_tc) begin
                        hold <= hold + 1'b1;
                    end else begin
                        hold <= '0;
                        if (ptr != len_q) begin
                            ptr <= ptr + 1'b1;
                        end else if (pass != iter_q) begin
                            ptr  <= '0;
                            pass <= pass + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state, pointer and table contents only.
    assign done = (state == ST_IDLE);
    assign en   = (state == ST_ACTIVE);
    assign sel  = (state == ST_ACTIVE) ? tbl_sel : sel_q;
    assign last = (state == ST_ACTIVE) && seq_end;

endmodule
